t_cap_reader: RTL and testbench
===============================

// Module: t_cap_reader
// PURPOSE
//  Reader/drain end of the ADC capture path. Buffers a triggered burst of merged
//  ADC words (merge_data/mereg_datv) in internal RAM, flags capr_rdy, then streams
//  the burst out through a valid/ready port to the PS/DDR side. Sits beside the
//  ADC capture block on the clk62 merge domain (single clock).
// PARAMETERS
//  DATA_W  56   merged word width (= ADC0_1)
//  AW      8    RAM address width; depth DEPTH = 2**AW
//  CNT_W   16   width of drop counter (CAPR_STAT_EN only)
// PORTS
//  clki        in   1        clock (merge domain)
//  rsti        in   1        asynchronous reset, active-low
//  mem_reset   in   1        synchronous abort/clear, highest priority
//  cap_len     in   AW+1     burst length in words, sampled on cap_arm
//  cap_arm     in   1        1-cycle pulse: arm capture
//  cap_trig    in   1        capture trigger (level, sampled each cycle)
//  merge_data  in   DATA_W   merged ADC word
//  mereg_datv  in   1        merge_data valid
//  cap_busy    out  1        high in ARM/FILL/RDOUT
//  capr_rdy    out  1        burst complete, readout in progress
//  rd_data     out  DATA_W   readout word
//  rd_valid    out  1        rd_data valid
//  rd_ready    in   1        sink accepts when rd_valid&rd_ready
//  rd_last     out  1        marks final word of burst (qualified by rd_valid)
//  drop_cnt    out  CNT_W    words lost (CAPR_STAT_EN only)
// BEHAVIOUR
//  Reset (rsti=0) and mem_reset: state=IDLE, all outputs 0, pointers 0,
//   drop_cnt 0. mem_reset wins over every simultaneous event; any burst lost.
//  Length: len_q <= (cap_len==0 || cap_len>DEPTH) ? DEPTH : cap_len, on cap_arm.
//  FSM:
//   IDLE : cap_arm -> ARM. cap_trig, mereg_datv ignored.
//   ARM  : cap_trig=1 -> FILL; if mereg_datv in same cycle that word is word 0.
//          cap_arm re-pulse ignored (len_q unchanged).
//   FILL : each mereg_datv writes RAM[wr_ptr], wr_ptr++. When write of word
//          len_q-1 occurs -> RDOUT next cycle; capr_rdy=1 from that cycle.
//          cap_trig level ignored after entry.
//   RDOUT: RAM read with 1-cycle latency behind an output holding register;
//          first rd_valid 2 cycles after entering RDOUT. rd_data/rd_last held
//          stable while rd_valid&!rd_ready. Back-to-back rd_ready=1 gives one
//          word per cycle (prefetch). rd_last=1 on word len_q-1. Handshake on
//          last word -> IDLE next cycle; capr_rdy, rd_valid, cap_busy drop to 0.
//          mereg_datv here is discarded (never overwrites buffer).
//  Words arrive in write order; rd_ptr wraps never (len_q<=DEPTH).
//  rd_valid never asserts outside RDOUT; no word duplicated or skipped.
// CONFIGURATION
//  CAPR_STAT_EN defined: drop_cnt increments (saturating at 2**CNT_W-1) for
//   every mereg_datv in RDOUT or ARM-before-trigger; cleared by reset/mem_reset
//   and on cap_arm accepted in IDLE.
//  Not defined: drop_cnt port tied to 0, no counter logic.
// TESTING
//  1 cap_len=4, arm, trig, 4 words 0x1..0x4, rd_ready=1 -> rd_data 1,2,3,4,
//    rd_last on 4th, capr_rdy 1 then 0, back to IDLE.
//  2 cap_len=0 -> 256 words captured (ramp 0..255); read with random rd_ready
//    stalls -> exact ramp out, data stable during stalls.
//  3 trig and mereg_datv same cycle in ARM, data 0xAA -> 0xAA is first word out.
//  4 mem_reset asserted mid-FILL after 3 of 8 words -> IDLE next cycle, no
//    rd_valid; new arm/trig of 2 words reads only the new 2 words.
//  5 CAPR_STAT_EN: 5 mereg_datv during RDOUT -> drop_cnt=5, buffer intact;
//    cap_arm -> drop_cnt=0.
//  6 rsti low during RDOUT -> all outputs 0 asynchronously; cap_trig in IDLE
//    without arm -> no capture.

Source files
------------

// File: rtl/t_cap_reader_if.sv
// ============================================================================
//  Module  : t_cap_reader_if
//  Brief   : Burst readout valid/ready port of the capture reader.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface t_cap_reader_if #(
    parameter int DATA_W = 56
);
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;

    modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
    modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

`default_nettype wire

// File: rtl/t_cap_reader.sv
// ============================================================================
//  Module  : t_cap_reader
//  Brief   : Buffers a triggered burst of merged ADC words, then streams it out
//            over a valid/ready port. Optional drop counter: CAPR_STAT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module t_cap_reader #(
    parameter int DATA_W = 56,
    parameter int AW     = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic              clki,
    input  wire logic              rsti,
    input  wire logic              mem_reset,
    input  wire logic [AW:0]       cap_len,
    input  wire logic              cap_arm,
    input  wire logic              cap_trig,
    input  wire logic [DATA_W-1:0] merge_data,
    input  wire logic              mereg_datv,
    output logic                   cap_busy,
    output logic                   capr_rdy,
    t_cap_reader_if.master         rd,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int          c_depth_n = 1 << AW;
    localparam logic [AW:0] c_depth   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_one     = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_FILL  = 2'd2,
        S_RDOUT = 2'd3
    } state_t;

    state_t            r_state;
    logic [AW:0]       r_len;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              r_busy;
    logic              r_rdy;
    logic              r_q_valid;
    logic              r_q_last;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_ram_q;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_mem [0:c_depth_n-1];

    logic [AW:0] w_len_sel;
    logic [AW:0] w_len_m1;
    logic        w_wr_en;
    logic        w_wr_last;
    logic        w_hs;
    logic        w_out_free;
    logic        w_rd_issue;

    assign w_len_sel  = (cap_len == '0 || cap_len > c_depth) ? c_depth : cap_len;
    assign w_len_m1   = r_len - c_one;
    assign w_wr_en    = !mem_reset && mereg_datv &&
                        ((r_state == S_ARM && cap_trig) || r_state == S_FILL);
    assign w_wr_last  = w_wr_en && (r_wr_ptr == w_len_m1);
    assign w_hs       = r_out_valid && rd.rd_ready;
    assign w_out_free = !r_out_valid || rd.rd_ready;
    // Prefetch a word whenever the RAM-output stage will be empty next cycle.
    assign w_rd_issue = !mem_reset && (r_state == S_RDOUT) && (r_rd_ptr < r_len) &&
                        (!r_q_valid || w_out_free);

    always_ff @(posedge clki) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= merge_data;
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b0;
            r_q_valid   <= 1'b0;
            r_q_last    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (mem_reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b0;
            r_q_valid   <= 1'b0;
            r_q_last    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cap_arm) begin
                        r_state  <= S_ARM;
                        r_busy   <= 1'b1;
                        r_len    <= w_len_sel;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                    end
                end
                S_ARM: begin
                    if (cap_trig) begin
                        if (w_wr_en) begin
                            r_wr_ptr <= r_wr_ptr + c_one;
                        end
                        if (w_wr_last) begin
                            r_state <= S_RDOUT;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + c_one;
                        if (w_wr_last) begin
                            r_state <= S_RDOUT;
                            r_rdy   <= 1'b1;
                        end
                    end
                end
                S_RDOUT: begin
                    if (w_rd_issue) begin
                        r_rd_ptr  <= r_rd_ptr + c_one;
                        r_q_valid <= 1'b1;
                        r_q_last  <= (r_rd_ptr == w_len_m1);
                    end else if (r_q_valid && w_out_free) begin
                        r_q_valid <= 1'b0;
                    end
                    if (w_hs && r_out_last) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_rdy       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_q_valid   <= 1'b0;
                    end else if (w_out_free) begin
                        // Holding register only reloads once its word is consumed.
                        r_out_valid <= r_q_valid;
                        if (r_q_valid) begin
                            r_out_data <= r_ram_q;
                            r_out_last <= r_q_last;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cap_busy    = r_busy;
    assign capr_rdy    = r_rdy;
    assign rd.rd_data  = r_out_data;
    assign rd.rd_valid = r_out_valid;
    assign rd.rd_last  = r_out_last;

`ifdef CAPR_STAT_EN
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_drop;

    assign w_drop = mereg_datv &&
                    (r_state == S_RDOUT || (r_state == S_ARM && !cap_trig));

    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti) begin
            r_drop_cnt <= '0;
        end else if (mem_reset) begin
            r_drop_cnt <= '0;
        end else if (r_state == S_IDLE && cap_arm) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != {CNT_W{1'b1}}) begin
            r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_t_cap_reader.sv
// ============================================================================
//  Module  : tb_t_cap_reader
//  Brief   : Directed self-checking bench for t_cap_reader.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_t_cap_reader;

    localparam int DATA_W = 56;
    localparam int AW     = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rsti;
    logic              mem_reset;
    logic [AW:0]       cap_len;
    logic              cap_arm;
    logic              cap_trig;
    logic [DATA_W-1:0] merge_data;
    logic              mereg_datv;
    logic              cap_busy;
    logic              capr_rdy;
    logic              rd_ready;
    logic [CNT_W-1:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_mem [0:255];

    t_cap_reader_if #(.DATA_W(DATA_W)) rd_if ();
    assign rd_if.rd_ready = rd_ready;

    t_cap_reader #(.DATA_W(DATA_W), .AW(AW), .CNT_W(CNT_W)) dut (
        .clki       (clk),
        .rsti       (rsti),
        .mem_reset  (mem_reset),
        .cap_len    (cap_len),
        .cap_arm    (cap_arm),
        .cap_trig   (cap_trig),
        .merge_data (merge_data),
        .mereg_datv (mereg_datv),
        .cap_busy   (cap_busy),
        .capr_rdy   (capr_rdy),
        .rd         (rd_if),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  {63'd0, cap_busy},       64'd0);
        check({tag, "_rdy"},   {63'd0, capr_rdy},       64'd0);
        check({tag, "_valid"}, {63'd0, rd_if.rd_valid}, 64'd0);
    endtask

    task automatic arm(input int len);
        cap_len = (AW+1)'(len);
        cap_arm = 1'b1;
        step();
        cap_arm = 1'b0;
    endtask

    // Writes n words from exp_mem; trigger rides on the first word when trig_with_data.
    task automatic fill(input int n, input bit trig_with_data);
        if (!trig_with_data) begin
            cap_trig = 1'b1;
            step();
            cap_trig = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            cap_trig   = trig_with_data && (i == 0);
            merge_data = exp_mem[i];
            mereg_datv = 1'b1;
            step();
        end
        cap_trig   = 1'b0;
        mereg_datv = 1'b0;
    endtask

    task automatic read_burst(input int n, input bit stall);
        int got = 0;
        int cyc = 0;
        bit was_stalled = 0;
        logic [DATA_W-1:0] held = '0;
        while (got < n && cyc < 3000) begin
            rd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (was_stalled) begin
                check("stall_hold", {7'd0, rd_if.rd_valid, rd_if.rd_data}, {7'd0, 1'b1, held});
            end
            if (rd_if.rd_valid && rd_ready) begin
                check("rd_data", {8'd0, rd_if.rd_data}, {8'd0, exp_mem[got]});
                check("rd_last", {63'd0, rd_if.rd_last}, {63'd0, got == n - 1});
                got++;
                was_stalled = 0;
            end else if (rd_if.rd_valid) begin
                held = rd_if.rd_data;
                was_stalled = 1;
            end
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        if (got < n) check("read_timeout", 64'(got), 64'(n));
    endtask

    initial begin
        rsti = 1'b0; mem_reset = 1'b0; cap_len = '0; cap_arm = 1'b0;
        cap_trig = 1'b0; merge_data = '0; mereg_datv = 1'b0; rd_ready = 1'b0;
        repeat (3) step();
        check_idle("reset");
        check("reset_data", {8'd0, rd_if.rd_data}, 64'd0);
        check("reset_last", {63'd0, rd_if.rd_last}, 64'd0);
        check("reset_drop", {48'd0, drop_cnt}, 64'd0);
        rsti = 1'b1;
        step();

        // Test 1: 4-word burst, latency and return to idle
        for (int i = 0; i < 4; i++) exp_mem[i] = DATA_W'(i + 1);
        arm(4);
        check("t1_busy", {63'd0, cap_busy}, 64'd1);
        fill(4, 1'b0);
        check("t1_rdy", {63'd0, capr_rdy}, 64'd1);
        check("t1_lat0", {63'd0, rd_if.rd_valid}, 64'd0);
        step();
        check("t1_lat1", {63'd0, rd_if.rd_valid}, 64'd0);
        step();
        check("t1_lat2", {63'd0, rd_if.rd_valid}, 64'd1);
        read_burst(4, 1'b0);
        check_idle("t1_end");

        // Test 2: cap_len=0 means full depth, ramp read with random stalls
        for (int i = 0; i < 256; i++) exp_mem[i] = DATA_W'(i);
        arm(0);
        fill(256, 1'b0);
        check("t2_rdy", {63'd0, capr_rdy}, 64'd1);
        read_burst(256, 1'b1);
        check_idle("t2_end");

        // Test 3: trigger and data in the same ARM cycle
        exp_mem[0] = 56'hAA; exp_mem[1] = 56'hBB;
        arm(2);
        fill(2, 1'b1);
        check("t3_rdy", {63'd0, capr_rdy}, 64'd1);
        read_burst(2, 1'b0);
        check_idle("t3_end");

        // Test 4: mem_reset mid-FILL, then a fresh 2-word burst
        for (int i = 0; i < 3; i++) exp_mem[i] = DATA_W'(56'h100 + i);
        arm(8);
        fill(3, 1'b0);
        mem_reset = 1'b1;
        step();
        mem_reset = 1'b0;
        check_idle("t4_abort");
        rd_ready = 1'b1;
        repeat (4) step();
        check_idle("t4_quiet");
        rd_ready = 1'b0;
        exp_mem[0] = 56'h21; exp_mem[1] = 56'h22;
        arm(2);
        fill(2, 1'b0);
        read_burst(2, 1'b0);
        check_idle("t4_end");

        // Test 5: words arriving during readout are dropped, buffer untouched
        for (int i = 0; i < 3; i++) exp_mem[i] = DATA_W'(56'h31 + i);
        arm(3);
        fill(3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            merge_data = 56'hEE;
            mereg_datv = 1'b1;
            step();
        end
        mereg_datv = 1'b0;
`ifdef CAPR_STAT_EN
        check("t5_drop", {48'd0, drop_cnt}, 64'd5);
`else
        check("t5_drop", {48'd0, drop_cnt}, 64'd0);
`endif
        read_burst(3, 1'b0);
        check_idle("t5_end");
        arm(3);
        check("t5_drop_clr", {48'd0, drop_cnt}, 64'd0);
        mem_reset = 1'b1;
        step();
        mem_reset = 1'b0;

        // Test 6: async reset during readout, trigger without arm
        exp_mem[0] = 56'h61; exp_mem[1] = 56'h62;
        arm(2);
        fill(2, 1'b0);
        repeat (3) step();
        check("t6_pre_valid", {63'd0, rd_if.rd_valid}, 64'd1);
        #2 rsti = 1'b0;
        #1;
        check_idle("t6_async");
        check("t6_async_data", {8'd0, rd_if.rd_data}, 64'd0);
        step();
        rsti = 1'b1;
        cap_trig = 1'b1;
        merge_data = 56'h77;
        mereg_datv = 1'b1;
        repeat (3) step();
        cap_trig = 1'b0;
        mereg_datv = 1'b0;
        repeat (3) step();
        check_idle("t6_no_arm");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
